// File: rtl/fetch_queue_pkg.sv
// Shared datapath defines plus the fetch-queue package: default sizes, the
// 0/1/2 transfer-amount type and the decode pop-request clamp.
`ifndef FETCH_QUEUE_DEFINES
`define FETCH_QUEUE_DEFINES
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`define FQ_DEPTH 8
`define FQ_POP_W 2
`endif

package fetch_queue_pkg;

  localparam int FQ_DEPTH_DEF    = `FQ_DEPTH;
  localparam int FQ_DWIDTH_DEF   = `DWIDTH;
  localparam int FQ_PC_WIDTH_DEF = `PC_WIDTH;
  localparam int FQ_POP_W        = `FQ_POP_W;

  // Entries moved through one side of the queue in a single cycle.
  typedef enum logic [1:0] {
    XFER_NONE = 2'd0,
    XFER_ONE  = 2'd1,
    XFER_TWO  = 2'd2
  } xfer_e;

  // Decode never retires more than two entries; a request of 3 means two.
  function automatic logic [FQ_POP_W-1:0] clamp_pop(input logic [FQ_POP_W-1:0] req);
    if (req > FQ_POP_W'(XFER_TWO)) begin
      return FQ_POP_W'(XFER_TWO);
    end
    return req;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch-queue storage: DEPTH x {pc, instr} registers, two write ports and two
// combinational read ports. Contents are not reset; validity lives in the count.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH    = FQ_DEPTH_DEF,
  parameter int DWIDTH   = FQ_DWIDTH_DEF,
  parameter int PC_WIDTH = FQ_PC_WIDTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     we1_i,
  input  logic                     we2_i,
  input  logic [$clog2(DEPTH)-1:0] waddr1_i,
  input  logic [$clog2(DEPTH)-1:0] waddr2_i,
  input  logic [PC_WIDTH-1:0]      wpc1_i,
  input  logic [DWIDTH-1:0]        winstr1_i,
  input  logic [PC_WIDTH-1:0]      wpc2_i,
  input  logic [DWIDTH-1:0]        winstr2_i,
  input  logic [$clog2(DEPTH)-1:0] raddr1_i,
  input  logic [$clog2(DEPTH)-1:0] raddr2_i,
  output logic [PC_WIDTH-1:0]      rpc1_o,
  output logic [DWIDTH-1:0]        rinstr1_o,
  output logic [PC_WIDTH-1:0]      rpc2_o,
  output logic [DWIDTH-1:0]        rinstr2_o
);

  localparam int EW = PC_WIDTH + DWIDTH;

  logic [EW-1:0] mem_q [DEPTH];

  // The two write addresses are always adjacent, so the ports never collide.
  always_ff @(posedge clk_i) begin
    if (we1_i) begin
      mem_q[waddr1_i] <= {wpc1_i, winstr1_i};
    end
    if (we2_i) begin
      mem_q[waddr2_i] <= {wpc2_i, winstr2_i};
    end
  end

  assign {rpc1_o, rinstr1_o} = mem_q[raddr1_i];
  assign {rpc2_o, rinstr2_o} = mem_q[raddr2_i];

endmodule

// File: rtl/fetch_queue.sv
// Dual-slot instruction fetch queue: accepts up to two fetched {pc, instr}
// pairs per cycle and presents the two oldest entries to dual-issue decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH    = FQ_DEPTH_DEF,
  parameter int DWIDTH   = FQ_DWIDTH_DEF,
  parameter int PC_WIDTH = FQ_PC_WIDTH_DEF
) (
  input  logic                    fq_clk,
  input  logic                    fq_rst,
  input  logic                    fq_i_ce,
  input  logic                    fq_i_flush,
  input  logic                    fq_i_valid_1,
  input  logic                    fq_i_valid_2,
  input  logic [DWIDTH-1:0]       fq_i_instr_1,
  input  logic [DWIDTH-1:0]       fq_i_instr_2,
  input  logic [PC_WIDTH-1:0]     fq_i_pc_1,
  input  logic [PC_WIDTH-1:0]     fq_i_pc_2,
  output logic                    fq_o_ready,
  input  logic [FQ_POP_W-1:0]     fq_i_pop_cnt,
  output logic                    fq_o_valid_1,
  output logic                    fq_o_valid_2,
  output logic [DWIDTH-1:0]       fq_o_instr_1,
  output logic [DWIDTH-1:0]       fq_o_instr_2,
  output logic [PC_WIDTH-1:0]     fq_o_pc_1,
  output logic [PC_WIDTH-1:0]     fq_o_pc_2,
  output logic [$clog2(DEPTH):0]  fq_o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_LIM = CW'(DEPTH - 2);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic                ready;
  logic [1:0]          push_req;
  logic [FQ_POP_W-1:0] pop_req;
  xfer_e               push_cnt, pop_cnt;
  logic [1:0]          push_n, pop_n;

  logic [PC_WIDTH-1:0] rpc1, rpc2;
  logic [DWIDTH-1:0]   rinstr1, rinstr2;

  // Ready only looks at the registered count; same-cycle pops earn no credit.
  assign ready    = (count_q <= READY_LIM);
  assign push_req = {1'b0, fq_i_valid_1} + {1'b0, fq_i_valid_1 & fq_i_valid_2};
  assign pop_req  = clamp_pop(fq_i_pop_cnt);

  always_comb begin
    push_cnt = XFER_NONE;
    pop_cnt  = XFER_NONE;
    if (fq_i_ce && !fq_i_flush) begin
      if (ready) begin
        push_cnt = xfer_e'(push_req);
      end
      // Never retire more than is held, so the head cannot pass the tail.
      if (count_q < CW'(pop_req)) begin
        pop_cnt = xfer_e'(count_q[1:0]);
      end else begin
        pop_cnt = xfer_e'(pop_req);
      end
    end
  end

  assign push_n = push_cnt;
  assign pop_n  = pop_cnt;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (fq_i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push_n);
      rd_ptr_d = rd_ptr_q + AW'(pop_n);
      count_d  = count_q + CW'(push_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge fq_clk) begin
    if (fq_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH    (DEPTH),
    .DWIDTH   (DWIDTH),
    .PC_WIDTH (PC_WIDTH)
  ) u_mem (
    .clk_i     (fq_clk),
    .we1_i     (push_n != 2'd0),
    .we2_i     (push_n == 2'd2),
    .waddr1_i  (wr_ptr_q),
    .waddr2_i  (wr_ptr_q + AW'(1)),
    .wpc1_i    (fq_i_pc_1),
    .winstr1_i (fq_i_instr_1),
    .wpc2_i    (fq_i_pc_2),
    .winstr2_i (fq_i_instr_2),
    .raddr1_i  (rd_ptr_q),
    .raddr2_i  (rd_ptr_q + AW'(1)),
    .rpc1_o    (rpc1),
    .rinstr1_o (rinstr1),
    .rpc2_o    (rpc2),
    .rinstr2_o (rinstr2)
  );

  // Stale array contents never leak out: invalid slots read as zero.
  assign fq_o_ready   = ready;
  assign fq_o_count   = count_q;
  assign fq_o_valid_1 = (count_q != '0);
  assign fq_o_valid_2 = (count_q >= CW'(2));
  assign fq_o_pc_1    = fq_o_valid_1 ? rpc1    : '0;
  assign fq_o_instr_1 = fq_o_valid_1 ? rinstr1 : '0;
  assign fq_o_pc_2    = fq_o_valid_2 ? rpc2    : '0;
  assign fq_o_instr_2 = fq_o_valid_2 ? rinstr2 : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// run against a queue-based FIFO model of the fetch/decode rules.
module tb_fetch_queue;

  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, ce, flush, v1, v2;
  logic [31:0] in1, in2, pc1, pc2;
  logic [1:0]  pop;
  logic        o_ready, o_v1, o_v2;
  logic [31:0] o_in1, o_in2, o_pc1, o_pc2;
  logic [3:0]  o_count;

  ent_t mq[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .DWIDTH(32), .PC_WIDTH(32)) dut (
    .fq_clk       (clk),
    .fq_rst       (rst),
    .fq_i_ce      (ce),
    .fq_i_flush   (flush),
    .fq_i_valid_1 (v1),
    .fq_i_valid_2 (v2),
    .fq_i_instr_1 (in1),
    .fq_i_instr_2 (in2),
    .fq_i_pc_1    (pc1),
    .fq_i_pc_2    (pc2),
    .fq_o_ready   (o_ready),
    .fq_i_pop_cnt (pop),
    .fq_o_valid_1 (o_v1),
    .fq_o_valid_2 (o_v2),
    .fq_o_instr_1 (o_in1),
    .fq_o_instr_2 (o_in2),
    .fq_o_pc_1    (o_pc1),
    .fq_o_pc_2    (o_pc2),
    .fq_o_count   (o_count)
  );

  function automatic logic [31:0] e_pc(int k);
    return (mq.size() > k) ? mq[k].pc : 32'd0;
  endfunction

  function automatic logic [31:0] e_in(int k);
    return (mq.size() > k) ? mq[k].instr : 32'd0;
  endfunction

  // Drive one cycle, advance the model with the same inputs, sample after the edge.
  task automatic step(input logic a_v1, a_v2, input logic [31:0] a_pc1, a_in1, a_pc2, a_in2,
                      input logic [1:0] a_pop, input logic a_ce, a_fl, a_rst);
    int   sz, np;
    bit   rdy;
    ent_t e;
    v1 = a_v1; v2 = a_v2; pc1 = a_pc1; in1 = a_in1; pc2 = a_pc2; in2 = a_in2;
    pop = a_pop; ce = a_ce; flush = a_fl; rst = a_rst;
    if (a_rst || a_fl) begin
      mq.delete();
    end else if (a_ce) begin
      sz  = mq.size();
      rdy = (DEPTH - sz) >= 2;
      np  = (a_pop > 2) ? 2 : int'(a_pop);
      if (np > sz) np = sz;
      repeat (np) void'(mq.pop_front());
      if (rdy && a_v1) begin
        e.pc = a_pc1; e.instr = a_in1; mq.push_back(e);
        if (a_v2) begin
          e.pc = a_pc2; e.instr = a_in2; mq.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic [31:0] pa, ia, pb, ib);
    step(1'b1, 1'b1, pa, ia, pb, ib, 2'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic push1(input logic [31:0] pa, ia);
    step(1'b1, 1'b0, pa, ia, 32'd0, 32'd0, 2'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic popn(input logic [1:0] n);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, n, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44, 2'd1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    total++; if (o_v1 !== 1'b0) begin bad++; $display("FAIL reset_v1 got %b exp 0", o_v1); end
    total++; if (o_v2 !== 1'b0) begin bad++; $display("FAIL reset_v2 got %b exp 0", o_v2); end
    total++; if (o_count !== 4'd0) begin bad++; $display("FAIL reset_count got %0d exp 0", o_count); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b exp 1", o_ready); end
    total++; if ({o_pc1, o_in1, o_pc2, o_in2} !== 128'd0)
      begin bad++; $display("FAIL reset_data got %h %h %h %h exp all 0", o_pc1, o_in1, o_pc2, o_in2); end
    rst = 1'b0;
  endtask

  task automatic test_pair();
    push2(32'h0, 32'h2001_0005, 32'h4, 32'h2002_0007);
    total++; if (o_count !== 4'd2) begin bad++; $display("FAIL pair_count got %0d exp 2", o_count); end
    total++; if (o_pc1 !== 32'h0 || o_in1 !== 32'h2001_0005)
      begin bad++; $display("FAIL pair_head got %h/%h exp 0/20010005", o_pc1, o_in1); end
    total++; if (o_pc2 !== 32'h4 || o_in2 !== 32'h2002_0007)
      begin bad++; $display("FAIL pair_next got %h/%h exp 4/20020007", o_pc2, o_in2); end
    popn(2'd2);
    total++; if (o_count !== 4'd0 || o_v1 !== 1'b0)
      begin bad++; $display("FAIL pair_drain got count %0d v1 %b exp 0 0", o_count, o_v1); end
  endtask

  task automatic test_fill_wrap();
    for (int k = 0; k < 4; k++)
      push2(32'(8 * k), 32'hA000_0000 | 32'(8 * k), 32'(8 * k + 4), 32'hA000_0000 | 32'(8 * k + 4));
    total++; if (o_count !== 4'd8 || o_ready !== 1'b0)
      begin bad++; $display("FAIL full got count %0d ready %b exp 8 0", o_count, o_ready); end
    push2(32'h100, 32'h1, 32'h104, 32'h2);
    total++; if (o_count !== 4'd8 || o_pc1 !== 32'h0)
      begin bad++; $display("FAIL full_drop got count %0d pc1 %h exp 8 0", o_count, o_pc1); end
    popn(2'd1);
    total++; if (o_count !== 4'd7 || o_ready !== 1'b0)
      begin bad++; $display("FAIL almost_full got count %0d ready %b exp 7 0", o_count, o_ready); end
    popn(2'd1);
    total++; if (o_count !== 4'd6 || o_ready !== 1'b1)
      begin bad++; $display("FAIL two_free got count %0d ready %b exp 6 1", o_count, o_ready); end
    push2(32'd32, 32'hA000_0020, 32'd36, 32'hA000_0024);
    total++; if (o_count !== 4'd8) begin bad++; $display("FAIL wrap_push got count %0d exp 8", o_count); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (o_pc1 !== 32'(8 + 8 * k) || o_pc2 !== 32'(12 + 8 * k) || o_in1 !== (32'hA000_0000 | 32'(8 + 8 * k)))
        begin bad++; $display("FAIL wrap_order%0d got %h %h %h exp %h %h", k, o_pc1, o_pc2, o_in1, 8 + 8 * k, 12 + 8 * k); end
      popn(2'd2);
    end
    total++; if (o_count !== 4'd0) begin bad++; $display("FAIL wrap_empty got count %0d exp 0", o_count); end
  endtask

  task automatic test_back_to_back();
    push2(32'h100, 32'hB100, 32'h104, 32'hB104);
    push1(32'h108, 32'hB108);
    step(1'b1, 1'b1, 32'h10C, 32'hB10C, 32'h110, 32'hB110, 2'd1, 1'b1, 1'b0, 1'b0);
    total++; if (o_count !== 4'd4 || o_pc1 !== 32'h104 || o_pc2 !== 32'h108)
      begin bad++; $display("FAIL simul got count %0d pc %h %h exp 4 104 108", o_count, o_pc1, o_pc2); end
    popn(2'd2);
    total++; if (o_pc1 !== 32'h10C || o_pc2 !== 32'h110 || o_in2 !== 32'hB110)
      begin bad++; $display("FAIL simul_order got %h %h %h exp 10c 110 b110", o_pc1, o_pc2, o_in2); end
    popn(2'd2);
  endtask

  task automatic test_flush();
    push2(32'h10, 32'h1, 32'h14, 32'h2);
    push2(32'h18, 32'h3, 32'h1C, 32'h4);
    push1(32'h20, 32'h5);
    step(1'b1, 1'b1, 32'h24, 32'h6, 32'h28, 32'h7, 2'd2, 1'b1, 1'b1, 1'b0);
    total++; if (o_count !== 4'd0 || o_v1 !== 1'b0 || o_pc1 !== 32'h0)
      begin bad++; $display("FAIL flush got count %0d v1 %b pc1 %h exp 0 0 0", o_count, o_v1, o_pc1); end
    push1(32'h40, 32'h4040);
    total++; if (o_count !== 4'd1 || o_pc1 !== 32'h40 || o_v2 !== 1'b0)
      begin bad++; $display("FAIL flush_refill got count %0d pc1 %h v2 %b exp 1 40 0", o_count, o_pc1, o_v2); end
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    total++; if (o_count !== 4'd0) begin bad++; $display("FAIL flush_no_ce got count %0d exp 0", o_count); end
  endtask

  task automatic test_clamps();
    push1(32'h200, 32'hC200);
    popn(2'd2);
    total++; if (o_count !== 4'd0 || o_v1 !== 1'b0)
      begin bad++; $display("FAIL pop_underflow got count %0d v1 %b exp 0 0", o_count, o_v1); end
    popn(2'd2);
    total++; if (o_count !== 4'd0) begin bad++; $display("FAIL pop_empty got count %0d exp 0", o_count); end
    push2(32'h300, 32'hC300, 32'h304, 32'hC304);
    push2(32'h308, 32'hC308, 32'h30C, 32'hC30C);
    popn(2'd3);
    total++; if (o_count !== 4'd2 || o_pc1 !== 32'h308)
      begin bad++; $display("FAIL pop3 got count %0d pc1 %h exp 2 308", o_count, o_pc1); end
    step(1'b0, 1'b1, 32'h400, 32'h1, 32'h404, 32'h2, 2'd0, 1'b1, 1'b0, 1'b0);
    total++; if (o_count !== 4'd2) begin bad++; $display("FAIL v2_only got count %0d exp 2", o_count); end
    step(1'b1, 1'b1, 32'h500, 32'h1, 32'h504, 32'h2, 2'd2, 1'b0, 1'b0, 1'b0);
    total++; if (o_count !== 4'd2 || o_pc1 !== 32'h308 || o_pc2 !== 32'h30C)
      begin bad++; $display("FAIL ce_hold got count %0d pc %h %h exp 2 308 30c", o_count, o_pc1, o_pc2); end
    step(1'b1, 1'b1, 32'h600, 32'h1, 32'h604, 32'h2, 2'd1, 1'b1, 1'b1, 1'b1);
    total++; if (o_count !== 4'd0 || o_ready !== 1'b1)
      begin bad++; $display("FAIL reset_prio got count %0d ready %b exp 0 1", o_count, o_ready); end
  endtask

  task automatic test_random();
    logic [31:0] pa;
    for (int i = 0; i < 400; i++) begin
      pa = $urandom;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), pa, $urandom, pa + 32'd4, $urandom,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 150) == 0));
      total++;
      if (o_count !== 4'(mq.size()) || o_ready !== ((DEPTH - mq.size()) >= 2) ||
          o_v1 !== (mq.size() >= 1) || o_v2 !== (mq.size() >= 2))
        begin bad++; $display("FAIL rand_ctl%0d got count %0d ready %b v %b%b exp count %0d", i, o_count, o_ready, o_v1, o_v2, mq.size()); end
      total++;
      if (o_pc1 !== e_pc(0) || o_in1 !== e_in(0) || o_pc2 !== e_pc(1) || o_in2 !== e_in(1))
        begin bad++; $display("FAIL rand_data%0d got %h %h %h %h exp %h %h %h %h", i, o_pc1, o_in1, o_pc2, o_in2, e_pc(0), e_in(0), e_pc(1), e_in(1)); end
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; flush = 1'b0; v1 = 1'b0; v2 = 1'b0;
    in1 = '0; in2 = '0; pc1 = '0; pc2 = '0; pop = '0;
    test_reset();
    test_pair();
    test_fill_wrap();
    test_back_to_back();
    test_flush();
    test_clamps();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
